tpwm_ramp_seq: RTL

//  Duty-ramp sequencer and bus arbiter in front of the tpwm T0/T1 timer-PWM peripheral.

---
 rtl/tpwm_seq_if.sv | 16 +
 rtl/tpwm_ramp_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpwm_seq_if.sv
// Register-bus bundle for the tpwm single-port register interface.
// The same bundle describes the CPU side (this block is the slave) and the
// peripheral side (this block is the master).
interface tpwm_seq_if #(
  parameter int AW = 13,
  parameter int DW = 16
);
  logic          sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;

  modport master (output sel, output addr, output din, output we, input dout);
  modport slave  (input sel, input addr, input din, input we, output dout);
endinterface

// File: rtl/tpwm_ramp_seq.sv
// Duty-ramp sequencer and bus arbiter in front of the tpwm T0/T1 peripheral.
// The CPU owns the register bus whenever it selects it; the sequencer only
// moves on cycles the CPU leaves free. The sequencer walks TCMPx from a start
// value to a target in fixed steps, advancing once every N PWM periods, where
// a period boundary is seen as TCNTx reading lower than its previous sample.
// Optional feature macro: TPWM_SEQ_LOCK_EN (block CPU writes to the active
// channel's TCMP register while a ramp is running).
module tpwm_ramp_seq #(
  parameter int            DW      = 16,
  parameter int            AW      = 13,
  parameter logic [AW-1:0] TCMP0_A = 'h03,
  parameter logic [AW-1:0] TCNT0_A = 'h04,
  parameter logic [AW-1:0] TCMP1_A = 'h06,
  parameter logic [AW-1:0] TCNT1_A = 'h07
) (
  input  logic          clk,
  input  logic          rst,
  tpwm_seq_if.slave     cpu,
  tpwm_seq_if.master    pwm,
  input  logic          ramp_start,
  input  logic          ramp_abort,
  input  logic          ramp_ch,
  input  logic [DW-1:0] ramp_from,
  input  logic [DW-1:0] ramp_to,
  input  logic [DW-1:0] ramp_step,
  input  logic [DW-1:0] ramp_ppd,
  output logic          ramp_busy,
  output logic          ramp_done,
  output logic          lock_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_SMP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched ramp configuration and progress.
  logic          r_ch;
  logic          r_up;
  logic [DW-1:0] r_to;
  logic [DW-1:0] r_step;
  logic [DW-1:0] r_ppd;
  logic [DW-1:0] r_cur;
  logic [DW-1:0] r_prev;
  logic [DW-1:0] r_pcnt;
  logic          r_lock_err;

  // FSM control strobes.
  logic          w_grant;
  logic          w_load;
  logic          w_sample;
  logic          w_advance;
  logic          w_pcnt_inc;

  // Sequencer bus request.
  logic          w_seq_we;
  logic [AW-1:0] w_seq_addr;
  logic [DW-1:0] w_seq_din;

  logic [AW-1:0] w_tcmp_a;
  logic [AW-1:0] w_tcnt_a;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_dif;
  logic [DW-1:0] w_next;
  logic [DW:0]   w_pcnt_p1;
  logic          w_ppd_hit;
  logic          w_wrap;
  logic          w_lock_hit;

  assign w_grant  = ~cpu.sel;
  assign w_tcmp_a = r_ch ? TCMP1_A : TCMP0_A;
  assign w_tcnt_a = r_ch ? TCNT1_A : TCNT0_A;

  // One extra bit keeps the step sum/difference from wrapping at DW, so the
  // clamp against the target always sees the true value.
  assign w_sum = {1'b0, r_cur} + {1'b0, r_step};
  assign w_dif = {1'b0, r_cur} - {1'b0, r_step};

  // Next compare value, clamped so the ramp never overshoots its target.
  always_comb begin
    if (r_up) begin
      w_next = (w_sum > {1'b0, r_to}) ? r_to : w_sum[DW-1:0];
    end else begin
      w_next = (w_dif[DW] || (w_dif[DW-1:0] < r_to)) ? r_to : w_dif[DW-1:0];
    end
  end

  // Period boundary: the counter read back lower than the previous sample.
  assign w_wrap    = (pwm.dout < r_prev);
  assign w_pcnt_p1 = {1'b0, r_pcnt} + 1'b1;
  assign w_ppd_hit = (w_pcnt_p1 == {1'b0, r_ppd});

  // Next-state and sequencer bus request; WR and RD wait for a free bus cycle,
  // SMP does not need the bus and always proceeds.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_seq_we    = 1'b0;
    w_seq_addr  = '0;
    w_seq_din   = '0;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_advance   = 1'b0;
    w_pcnt_inc  = 1'b0;
    if (ramp_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ramp_start) begin
            w_load      = 1'b1;
            w_state_nxt = S_WR;
          end
        end
        S_WR: begin
          if (w_grant) begin
            w_seq_we    = 1'b1;
            w_seq_addr  = w_tcmp_a;
            w_seq_din   = r_cur;
            w_state_nxt = (r_cur == r_to) ? S_DONE : S_RD;
          end
        end
        S_RD: begin
          if (w_grant) begin
            w_seq_addr  = w_tcnt_a;
            w_state_nxt = S_SMP;
          end
        end
        S_SMP: begin
          w_sample = 1'b1;
          if (w_wrap && w_ppd_hit) begin
            w_advance   = 1'b1;
            w_state_nxt = S_WR;
          end else begin
            w_pcnt_inc  = w_wrap;
            w_state_nxt = S_RD;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ramp configuration, current value, last counter sample and period count.
  always_ff @(posedge clk) begin
    // NOTE: configuration registers are reset too so a ramp never starts from stale settings after rst.
    if (rst) begin
      r_ch   <= 1'b0;
      r_up   <= 1'b0;
      r_to   <= '0;
      r_step <= '0;
      r_ppd  <= '0;
      r_cur  <= '0;
      r_prev <= '0;
      r_pcnt <= '0;
    end else if (w_load) begin
      r_ch   <= ramp_ch;
      r_up   <= (ramp_from <= ramp_to);
      r_to   <= ramp_to;
      r_step <= (ramp_step == '0) ? DW'(1) : ramp_step;
      r_ppd  <= (ramp_ppd == '0) ? DW'(1) : ramp_ppd;
      r_cur  <= ramp_from;
      r_prev <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_sample) begin
        r_prev <= pwm.dout;
      end
      if (w_advance) begin
        r_cur  <= w_next;
        r_pcnt <= '0;
      end else if (w_pcnt_inc) begin
        r_pcnt <= w_pcnt_p1[DW-1:0];
      end
    end
  end

`ifdef TPWM_SEQ_LOCK_EN
  assign w_lock_hit = cpu.sel & cpu.we & ramp_busy & (cpu.addr == w_tcmp_a);
`else
  assign w_lock_hit = 1'b0;
`endif

  // One-cycle error pulse after a blocked CPU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_err <= 1'b0;
    end else begin
      r_lock_err <= w_lock_hit;
    end
  end

  // Bus mux: the CPU has fixed priority; otherwise the sequencer drives it.
  always_comb begin
    if (cpu.sel) begin
      pwm.addr = cpu.addr;
      pwm.din  = cpu.din;
      pwm.we   = cpu.we & ~w_lock_hit;
    end else begin
      pwm.addr = w_seq_addr;
      pwm.din  = w_seq_din;
      pwm.we   = w_seq_we;
    end
  end

  assign pwm.sel   = cpu.sel | ramp_busy;
  assign cpu.dout  = pwm.dout;
  assign ramp_busy = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_SMP);
  assign ramp_done = (r_state == S_DONE) && !ramp_abort;
  assign lock_err  = r_lock_err;

endmodule
